// File: rtl/riscv_types.sv
// Shared RV32I definitions for the issue stage: ALU operations, opcode and funct
// constants, and the decoded-instruction record.
package riscv_types;

    typedef enum logic [3:0] {
        alu_add  = 4'd0,
        alu_sub  = 4'd1,
        alu_sll  = 4'd2,
        alu_slt  = 4'd3,
        alu_sltu = 4'd4,
        alu_xor  = 4'd5,
        alu_srl  = 4'd6,
        alu_sra  = 4'd7,
        alu_or   = 4'd8,
        alu_and  = 4'd9
    } aluop_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        aluop_t      op;
        logic [31:0] opa;
        logic [31:0] opb;
        logic [4:0]  rd;
        logic        rd_we;
        logic        illegal;
        logic        use_rs1;
        logic        use_rs2;
    } decoded_t;

    // alt selects the funct7=0100000 variant, which only exists for add/sub and srl/sra
    function automatic aluop_t f3_to_aluop(input logic [2:0] f3, input logic alt);
        aluop_t op;
        op = alu_add;
        case (f3)
            F3_ADD:  op = alt ? alu_sub : alu_add;
            F3_SLL:  op = alu_sll;
            F3_SLT:  op = alu_slt;
            F3_SLTU: op = alu_sltu;
            F3_XOR:  op = alu_xor;
            F3_SR:   op = alt ? alu_sra : alu_srl;
            F3_OR:   op = alu_or;
            F3_AND:  op = alu_and;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_scoreboard.sv
// Busy-bit scoreboard for in-flight destination registers. Set beats clear on
// the same register in one cycle; x0 is never reported busy.
module alu_scoreboard
    import riscv_types::*;
#(
    parameter  int NREGS = 32,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    input  logic          set_en_in,
    input  logic [AW-1:0] set_addr_in,
    input  logic          clr_en_in,
    input  logic [AW-1:0] clr_addr_in,
    input  logic          flush_clr_en_in,
    input  logic [AW-1:0] flush_clr_addr_in,
    input  logic [AW-1:0] rs1_addr_in,
    input  logic [AW-1:0] rs2_addr_in,
    output logic          rs1_busy_out,
    output logic          rs2_busy_out
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (clr_en_in) begin
            busy_d[clr_addr_in] = 1'b0;
        end
        if (flush_clr_en_in) begin
            busy_d[flush_clr_addr_in] = 1'b0;
        end
        if (set_en_in) begin
            busy_d[set_addr_in] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign rs1_busy_out = busy_q[rs1_addr_in] && (rs1_addr_in != '0);
    assign rs2_busy_out = busy_q[rs2_addr_in] && (rs2_addr_in != '0);

endmodule

// File: rtl/alu_issue.sv
// Decode/issue stage: turns RV32I OP/OP-IMM/LUI/AUIPC into a registered ALU request,
// stalling fetch on RAW hazards. Define ALU_ISSUE_BYPASS_EN to forward same-cycle writeback data.
module alu_issue
    import riscv_types::*;
#(
    parameter int WIDTH = 32,
    parameter int NREGS = 32
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             instr_valid_in,
    output logic             instr_ready_out,
    input  logic [31:0]      instr_in,
    input  logic [WIDTH-1:0] pc_in,
    output logic [4:0]       rf_rs1_addr_out,
    output logic [4:0]       rf_rs2_addr_out,
    input  logic [WIDTH-1:0] rf_rs1_data_in,
    input  logic [WIDTH-1:0] rf_rs2_data_in,
    output aluop_t           ctrl_out,
    output logic [WIDTH-1:0] rs1_out,
    output logic [WIDTH-1:0] rs2_out,
    output logic [4:0]       rd_addr_out,
    output logic             rd_we_out,
    output logic             illegal_out,
    output logic             out_valid_out,
    input  logic             out_ready_in,
    input  logic             wb_valid_in,
    input  logic [4:0]       wb_addr_in,
    input  logic [WIDTH-1:0] wb_data_in,
    input  logic             flush_in
);

    logic [6:0]       opcode;
    logic [6:0]       funct7;
    logic [2:0]       funct3;
    logic [4:0]       rs1_addr;
    logic [4:0]       rs2_addr;
    logic [WIDTH-1:0] imm_i;
    logic [WIDTH-1:0] imm_u;
    logic [WIDTH-1:0] shamt;
    logic [WIDTH-1:0] src1_data;
    logic [WIDTH-1:0] src2_data;
    logic             rs1_busy;
    logic             rs2_busy;
    logic             rs1_blocked;
    logic             rs2_blocked;
    logic             hazard;
    logic             accept;
    decoded_t         dec;

    logic             out_valid_q, out_valid_d;
    aluop_t           ctrl_q, ctrl_d;
    logic [WIDTH-1:0] rs1_q, rs1_d;
    logic [WIDTH-1:0] rs2_q, rs2_d;
    logic [4:0]       rd_q, rd_d;
    logic             rd_we_q, rd_we_d;
    logic             illegal_q, illegal_d;

    assign opcode   = instr_in[6:0];
    assign funct3   = instr_in[14:12];
    assign funct7   = instr_in[31:25];
    assign rs1_addr = instr_in[19:15];
    assign rs2_addr = instr_in[24:20];
    assign imm_i    = {{(WIDTH-12){instr_in[31]}}, instr_in[31:20]};
    assign imm_u    = {instr_in[31:12], 12'b0};
    assign shamt    = {{(WIDTH-5){1'b0}}, instr_in[24:20]};

    assign rf_rs1_addr_out = rs1_addr;
    assign rf_rs2_addr_out = rs2_addr;

`ifdef ALU_ISSUE_BYPASS_EN
    // A writeback landing this cycle both releases the hazard and supplies the operand
    logic fwd1;
    logic fwd2;
    assign fwd1        = wb_valid_in && (wb_addr_in == rs1_addr) && (rs1_addr != '0);
    assign fwd2        = wb_valid_in && (wb_addr_in == rs2_addr) && (rs2_addr != '0);
    assign src1_data   = fwd1 ? wb_data_in : rf_rs1_data_in;
    assign src2_data   = fwd2 ? wb_data_in : rf_rs2_data_in;
    assign rs1_blocked = rs1_busy && !fwd1;
    assign rs2_blocked = rs2_busy && !fwd2;
`else
    logic unused_wb_data;
    assign unused_wb_data = ^wb_data_in;
    assign src1_data      = rf_rs1_data_in;
    assign src2_data      = rf_rs2_data_in;
    assign rs1_blocked    = rs1_busy;
    assign rs2_blocked    = rs2_busy;
`endif

    always_comb begin
        dec    = '0;
        dec.op = alu_add;
        dec.rd = instr_in[11:7];
        case (opcode)
            OPC_OP: begin
                dec.use_rs1 = 1'b1;
                dec.use_rs2 = 1'b1;
                dec.opa     = src1_data;
                dec.opb     = src2_data;
                dec.op      = f3_to_aluop(funct3, funct7 == F7_ALT);
                dec.illegal = !((funct7 == F7_BASE) ||
                                ((funct7 == F7_ALT) && ((funct3 == F3_ADD) || (funct3 == F3_SR))));
            end
            OPC_OP_IMM: begin
                dec.use_rs1 = 1'b1;
                dec.opa     = src1_data;
                dec.opb     = imm_i;
                dec.op      = f3_to_aluop(funct3, (funct3 == F3_SR) && (funct7 == F7_ALT));
                if ((funct3 == F3_SLL) || (funct3 == F3_SR)) begin
                    dec.opb     = shamt;
                    dec.illegal = !((funct7 == F7_BASE) ||
                                    ((funct3 == F3_SR) && (funct7 == F7_ALT)));
                end
            end
            OPC_LUI: begin
                dec.opb = imm_u;
            end
            OPC_AUIPC: begin
                dec.opa = pc_in;
                dec.opb = imm_u;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
        if (dec.illegal) begin
            dec.op  = alu_add;
            dec.opa = '0;
            dec.opb = '0;
        end
        dec.rd_we = !dec.illegal && (dec.rd != '0);
    end

    assign hazard = instr_valid_in &&
                    ((dec.use_rs1 && rs1_blocked) || (dec.use_rs2 && rs2_blocked));
    assign instr_ready_out = (!out_valid_q || out_ready_in) && !hazard && !flush_in;
    assign accept          = instr_valid_in && instr_ready_out;

    alu_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk_in            (clk_in),
        .rst_n_in          (rst_n_in),
        .set_en_in         (accept && dec.rd_we),
        .set_addr_in       (dec.rd),
        .clr_en_in         (wb_valid_in),
        .clr_addr_in       (wb_addr_in),
        .flush_clr_en_in   (flush_in && out_valid_q && rd_we_q),
        .flush_clr_addr_in (rd_q),
        .rs1_addr_in       (rs1_addr),
        .rs2_addr_in       (rs2_addr),
        .rs1_busy_out      (rs1_busy),
        .rs2_busy_out      (rs2_busy)
    );

    // Fields only change on accept, so they hold while execute applies backpressure
    always_comb begin
        out_valid_d = out_valid_q;
        ctrl_d      = ctrl_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        rd_we_d     = rd_we_q;
        illegal_d   = illegal_q;
        if (flush_in) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            ctrl_d      = dec.op;
            rs1_d       = dec.opa;
            rs2_d       = dec.opb;
            rd_d        = dec.rd;
            rd_we_d     = dec.rd_we;
            illegal_d   = dec.illegal;
        end else if (out_ready_in) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            out_valid_q <= 1'b0;
            ctrl_q      <= alu_add;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            rd_we_q     <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            ctrl_q      <= ctrl_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            rd_we_q     <= rd_we_d;
            illegal_q   <= illegal_d;
        end
    end

    assign out_valid_out = out_valid_q;
    assign ctrl_out      = ctrl_q;
    assign rs1_out       = rs1_q;
    assign rs2_out       = rs2_q;
    assign rd_addr_out   = rd_q;
    assign rd_we_out     = rd_we_q;
    assign illegal_out   = illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed RAW, illegal, backpressure and flush cases
// pinned with literals, then randomized traffic against an instruction-level reference model.
module tb_alu_issue;
    import riscv_types::*;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        instr_valid_in;
    logic        instr_ready_out;
    logic [31:0] instr_in;
    logic [31:0] pc_in;
    logic [4:0]  rf_rs1_addr_out;
    logic [4:0]  rf_rs2_addr_out;
    logic [31:0] rf_rs1_data_in;
    logic [31:0] rf_rs2_data_in;
    aluop_t      ctrl_out;
    logic [31:0] rs1_out;
    logic [31:0] rs2_out;
    logic [4:0]  rd_addr_out;
    logic        rd_we_out;
    logic        illegal_out;
    logic        out_valid_out;
    logic        out_ready_in;
    logic        wb_valid_in;
    logic [4:0]  wb_addr_in;
    logic [31:0] wb_data_in;
    logic        flush_in;

    logic [31:0] regs [32];
    assign rf_rs1_data_in = regs[rf_rs1_addr_out];
    assign rf_rs2_data_in = regs[rf_rs2_addr_out];

    always #5 clk_in = ~clk_in;

    alu_issue dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .instr_valid_in  (instr_valid_in),
        .instr_ready_out (instr_ready_out),
        .instr_in        (instr_in),
        .pc_in           (pc_in),
        .rf_rs1_addr_out (rf_rs1_addr_out),
        .rf_rs2_addr_out (rf_rs2_addr_out),
        .rf_rs1_data_in  (rf_rs1_data_in),
        .rf_rs2_data_in  (rf_rs2_data_in),
        .ctrl_out        (ctrl_out),
        .rs1_out         (rs1_out),
        .rs2_out         (rs2_out),
        .rd_addr_out     (rd_addr_out),
        .rd_we_out       (rd_we_out),
        .illegal_out     (illegal_out),
        .out_valid_out   (out_valid_out),
        .out_ready_in    (out_ready_in),
        .wb_valid_in     (wb_valid_in),
        .wb_addr_in      (wb_addr_in),
        .wb_data_in      (wb_data_in),
        .flush_in        (flush_in)
    );

    typedef struct {
        aluop_t      op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
        logic        use1;
        logic        use2;
    } ref_t;

    // Reference model state: what the output register and busy set must hold
    logic        m_valid;
    ref_t        m_out;
    bit          m_busy [32];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ref_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic [31:0] v1, input logic [31:0] v2);
        ref_t        r;
        aluop_t      tbl [8];
        logic [6:0]  f7;
        logic [2:0]  f3;
        tbl    = '{alu_add, alu_sll, alu_slt, alu_sltu, alu_xor, alu_srl, alu_or, alu_and};
        f7     = ins[31:25];
        f3     = ins[14:12];
        r.op   = alu_add;
        r.a    = 32'd0;
        r.b    = 32'd0;
        r.rd   = ins[11:7];
        r.ill  = 1'b0;
        r.use1 = 1'b0;
        r.use2 = 1'b0;
        if (ins[6:0] == 7'h33) begin
            r.use1 = 1'b1;
            r.use2 = 1'b1;
            r.a    = v1;
            r.b    = v2;
            r.op   = tbl[f3];
            if (f7 == 7'h20 && f3 == 3'd0)      r.op  = alu_sub;
            else if (f7 == 7'h20 && f3 == 3'd5) r.op  = alu_sra;
            else if (f7 != 7'h00)               r.ill = 1'b1;
        end else if (ins[6:0] == 7'h13) begin
            r.use1 = 1'b1;
            r.a    = v1;
            r.op   = tbl[f3];
            if (f3 == 3'd1 || f3 == 3'd5) begin
                r.b = {27'd0, ins[24:20]};
                if (f3 == 3'd5 && f7 == 7'h20) r.op  = alu_sra;
                else if (f7 != 7'h00)          r.ill = 1'b1;
            end else begin
                r.b = {{20{ins[31]}}, ins[31:20]};
            end
        end else if (ins[6:0] == 7'h37) begin
            r.b = {ins[31:12], 12'h000};
        end else if (ins[6:0] == 7'h17) begin
            r.a = pc;
            r.b = {ins[31:12], 12'h000};
        end else begin
            r.ill = 1'b1;
        end
        if (r.ill) r.op = alu_add;
        r.we = !r.ill && (r.rd != 5'd0);
        return r;
    endfunction

    function automatic logic src_blocked(input logic [4:0] a, input logic wbv, input logic [4:0] wba);
        logic blk;
        blk = m_busy[a] && (a != 5'd0);
`ifdef ALU_ISSUE_BYPASS_EN
        if (wbv && wba == a) blk = 1'b0;
`else
        if (wbv && wba == a && 1'b0) blk = 1'b0;
`endif
        return blk;
    endfunction

    task automatic check_output();
        check("out_valid", 32'(out_valid_out), 32'(m_valid));
        if (m_valid) begin
            check("ctrl", 32'(ctrl_out), 32'(m_out.op));
            check("rd_we", 32'(rd_we_out), 32'(m_out.we));
            check("illegal", 32'(illegal_out), 32'(m_out.ill));
            if (!m_out.ill) begin
                check("rs1_out", rs1_out, m_out.a);
                check("rs2_out", rs2_out, m_out.b);
                check("rd_addr", 32'(rd_addr_out), 32'(m_out.rd));
            end
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    endtask

    task automatic apply_stimulus(input logic v, input logic [31:0] ins, input logic rdy,
                                  input logic wbv, input logic [4:0] wba, input logic [31:0] wbd,
                                  input logic fl, output logic ready_seen);
        ref_t        r;
        logic [31:0] s1;
        logic [31:0] s2;
        logic        haz;
        logic        exp_ready;
        logic        acc;
        @(negedge clk_in);
        check_output();
        instr_valid_in = v;
        instr_in       = ins;
        pc_in          = $urandom & 32'hFFFF_FFFC;
        out_ready_in   = rdy;
        wb_valid_in    = wbv;
        wb_addr_in     = wba;
        wb_data_in     = wbd;
        flush_in       = fl;
        #1;
        s1 = regs[ins[19:15]];
        s2 = regs[ins[24:20]];
`ifdef ALU_ISSUE_BYPASS_EN
        if (wbv && wba != 5'd0 && wba == ins[19:15]) s1 = wbd;
        if (wbv && wba != 5'd0 && wba == ins[24:20]) s2 = wbd;
`endif
        r   = ref_decode(ins, pc_in, s1, s2);
        haz = v && ((r.use1 && src_blocked(ins[19:15], wbv, wba)) ||
                    (r.use2 && src_blocked(ins[24:20], wbv, wba)));
        exp_ready = (!m_valid || rdy) && !haz && !fl;
        check("instr_ready", 32'(instr_ready_out), 32'(exp_ready));
        check("rf_rs1_addr", 32'(rf_rs1_addr_out), 32'(ins[19:15]));
        check("rf_rs2_addr", 32'(rf_rs2_addr_out), 32'(ins[24:20]));
        ready_seen = instr_ready_out;
        acc = v && exp_ready;
        @(posedge clk_in);
        if (wbv) m_busy[wba] = 1'b0;
        if (fl && m_valid && m_out.we) m_busy[m_out.rd] = 1'b0;
        if (acc && r.we) m_busy[r.rd] = 1'b1;
        if (fl) m_valid = 1'b0;
        else if (acc) begin
            m_valid = 1'b1;
            m_out   = r;
        end else if (rdy) m_valid = 1'b0;
    endtask

    task automatic idle_inputs();
        instr_valid_in = 1'b0;
        instr_in       = 32'd0;
        pc_in          = 32'd0;
        out_ready_in   = 1'b1;
        wb_valid_in    = 1'b0;
        wb_addr_in     = 5'd0;
        wb_data_in     = 32'd0;
        flush_in       = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          k;
        int          f;
        w       = $urandom;
        k       = $urandom_range(0, 9);
        f       = $urandom_range(0, 3);
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        w[11:7]  = 5'($urandom_range(0, 7));
        case (k)
            0, 1, 2: begin
                w[6:0] = 7'h33;
                if (f < 2)       w[31:25] = 7'h00;
                else if (f == 2) w[31:25] = 7'h20;
            end
            3, 4, 5: begin
                w[6:0] = 7'h13;
                if (w[14:12] == 3'd1 || w[14:12] == 3'd5) begin
                    if (f < 2)       w[31:25] = 7'h00;
                    else if (f == 2) w[31:25] = 7'h20;
                end
            end
            6:       w[6:0] = 7'h37;
            7:       w[6:0] = 7'h17;
            8:       w[6:0] = 7'h33;
            default: ;
        endcase
        return w;
    endfunction

    logic rdy_seen;

    initial begin
        idle_inputs();
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[0] = 32'd0;
        regs[1] = 32'd5;
        regs[2] = 32'd7;
        regs[3] = 32'h33;
        model_reset();
        rst_n_in = 1'b0;
        #12;
        check("rst_out_valid", 32'(out_valid_out), 32'd0);
        check("rst_ctrl", 32'(ctrl_out), 32'(alu_add));
        check("rst_rs1", rs1_out, 32'd0);
        check("rst_rs2", rs2_out, 32'd0);
        check("rst_rd", 32'(rd_addr_out), 32'd0);
        check("rst_rd_we", 32'(rd_we_out), 32'd0);
        check("rst_illegal", 32'(illegal_out), 32'd0);
        check("rst_ready", 32'(instr_ready_out), 32'd1);
        @(negedge clk_in);
        rst_n_in = 1'b1;

        // add x3,x1,x2
        apply_stimulus(1, 32'h002081B3, 1, 0, 5'd0, 32'd0, 0, rdy_seen);
        #1;
        check("add_valid", 32'(out_valid_out), 32'd1);
        check("add_ctrl", 32'(ctrl_out), 32'(alu_add));
        check("add_rs1", rs1_out, 32'd5);
        check("add_rs2", rs2_out, 32'd7);
        check("add_rd", 32'(rd_addr_out), 32'd3);
        check("add_we", 32'(rd_we_out), 32'd1);

        // add x4,x3,x1 must wait for x3
        apply_stimulus(1, 32'h00118233, 1, 0, 5'd0, 32'd0, 0, rdy_seen);
        check("raw_stall", 32'(rdy_seen), 32'd0);
        apply_stimulus(1, 32'h00118233, 1, 1, 5'd3, 32'hABCD0003, 0, rdy_seen);
`ifdef ALU_ISSUE_BYPASS_EN
        check("raw_bypass_ready", 32'(rdy_seen), 32'd1);
        #1;
        check("raw_bypass_rs1", rs1_out, 32'hABCD0003);
`else
        check("raw_wb_still_stall", 32'(rdy_seen), 32'd0);
        apply_stimulus(1, 32'h00118233, 1, 0, 5'd0, 32'd0, 0, rdy_seen);
        check("raw_released", 32'(rdy_seen), 32'd1);
        #1;
        check("raw_rs1", rs1_out, 32'h33);
        check("raw_rs2", rs2_out, 32'd5);
        check("raw_rd", 32'(rd_addr_out), 32'd4);
`endif

        apply_stimulus(1, 32'hFFF00293, 1, 0, 5'd0, 32'd0, 0, rdy_seen);
        #1;
        check("addi_rs1", rs1_out, 32'd0);
        check("addi_rs2", rs2_out, 32'hFFFF_FFFF);
        check("addi_ctrl", 32'(ctrl_out), 32'(alu_add));
        check("addi_rd", 32'(rd_addr_out), 32'd5);

        apply_stimulus(1, 32'h123453B7, 1, 0, 5'd0, 32'd0, 0, rdy_seen);
        #1;
        check("lui_rs1", rs1_out, 32'd0);
        check("lui_rs2", rs2_out, 32'h1234_5000);
        check("lui_rd", 32'(rd_addr_out), 32'd7);

        apply_stimulus(1, 32'h402081B3, 1, 0, 5'd0, 32'd0, 0, rdy_seen);
        #1;
        check("sub_ctrl", 32'(ctrl_out), 32'(alu_sub));

        // illegal funct7 while x3 retires: x3 must end up free
        apply_stimulus(1, 32'h422081B3, 1, 1, 5'd3, 32'd0, 0, rdy_seen);
        #1;
        check("ill_flag", 32'(illegal_out), 32'd1);
        check("ill_we", 32'(rd_we_out), 32'd0);
        check("ill_ctrl", 32'(ctrl_out), 32'(alu_add));
        apply_stimulus(1, 32'h00118233, 1, 0, 5'd0, 32'd0, 0, rdy_seen);
        check("ill_no_busy", 32'(rdy_seen), 32'd1);

        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1, 32'h002081B3, 0, 0, 5'd0, 32'd0, 0, rdy_seen);
            check("bp_ready", 32'(rdy_seen), 32'd0);
            #1;
            check("bp_valid", 32'(out_valid_out), 32'd1);
            check("bp_rd", 32'(rd_addr_out), 32'd4);
            check("bp_rs1", rs1_out, 32'h33);
        end
        apply_stimulus(1, 32'h002081B3, 0, 0, 5'd0, 32'd0, 1, rdy_seen);
        check("flush_ready", 32'(rdy_seen), 32'd0);
        #1;
        check("flush_valid", 32'(out_valid_out), 32'd0);
        // add x5,x4,x0 proves busy[4] was released by the flush
        apply_stimulus(1, 32'h000202B3, 1, 0, 5'd0, 32'd0, 0, rdy_seen);
        check("flush_busy_cleared", 32'(rdy_seen), 32'd1);

        for (int n = 0; n < 3000; n++) begin
            apply_stimulus(($urandom_range(0, 3) != 0), rand_instr(), ($urandom_range(0, 3) != 0),
                           ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom,
                           ($urandom_range(0, 19) == 0), rdy_seen);
            if (n == 1500) begin
                #2 rst_n_in = 1'b0;
                #1;
                check("async_rst_valid", 32'(out_valid_out), 32'd0);
                check("async_rst_ctrl", 32'(ctrl_out), 32'(alu_add));
                idle_inputs();
                model_reset();
                @(negedge clk_in);
                rst_n_in = 1'b1;
            end
        end

        @(negedge clk_in);
        check_output();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Decode/issue stage that drives the ALU interface: takes a 32-bit RV32I instruction from fetch and produces the ALU opcode, both operands and the destination register in a registered output.
- Decodes the integer ALU subset: OP, OP-IMM, LUI and AUIPC.
- Reads the register file through combinational read ports.
- Tracks in-flight destinations with a scoreboard and stalls fetch on read-after-write hazards.
- Sits between fetch and the execute stage.

Parameters:
- WIDTH, 32, datapath and operand width; only 32 is supported.
- NREGS, 32, number of architectural registers; index width is $clog2(NREGS).

Ports:
- clk_in  input  1  clock; all state updates on its rising edge.
- rst_n_in  input  1  reset, asynchronous, active-low.
- instr_valid_in  input  1  fetch offers an instruction.
- instr_ready_out  output  1  stage accepts this cycle.
- instr_in  input  32  instruction word.
- pc_in  input  WIDTH  PC of instr_in, used by AUIPC.
- rf_rs1_addr_out  output  5  register file read address A, equal to instr_in[19:15].
- rf_rs2_addr_out  output  5  register file read address B, equal to instr_in[24:20].
- rf_rs1_data_in  input  WIDTH  read data A, valid in the same cycle.
- rf_rs2_data_in  input  WIDTH  read data B, valid in the same cycle.
- ctrl_out  output  aluop_t  ALU operation.
- rs1_out  output  WIDTH  ALU operand A.
- rs2_out  output  WIDTH  ALU operand B.
- rd_addr_out  output  5  destination register.
- rd_we_out  output  1  result must be written back.
- illegal_out  output  1  instruction not in the supported subset.
- out_valid_out  output  1  output register holds an instruction.
- out_ready_in  input  1  execute consumes the output.
- wb_valid_in  input  1  writeback retires a destination this cycle.
- wb_addr_in  input  5  register being written back.
- wb_data_in  input  WIDTH  writeback data; used only when ALU_ISSUE_BYPASS_EN is defined.
- flush_in  input  1  discard the output-register contents.

Behaviour:

Reset values:
- out_valid_out=0, all busy bits=0, ctrl_out=alu_add.
- rs1_out, rs2_out, rd_addr_out, rd_we_out and illegal_out are all 0.

Handshake and latency:
- An instruction is accepted when instr_valid_in && instr_ready_out.
- The output is consumed when out_valid_out && out_ready_in.
- instr_ready_out = (!out_valid_out || out_ready_in) && !hazard && !flush_in.
- Latency is 1 cycle: an instruction accepted in cycle N appears at the outputs in N+1.
- Throughput is 1 instruction per cycle while execute keeps out_ready_in high.
- Output fields hold stable while out_valid_out && !out_ready_in.

Decode (funct3):
- 000: add. OP with funct7=0100000 gives sub. OP-IMM 000 is always add.
- 001: sll.
- 010: slt.
- 011: sltu.
- 100: xor.
- 101: srl when funct7=0000000, sra when funct7=0100000.
- 110: or.
- 111: and.

Decode (operands):
- OP-IMM immediate is sign-extended instr[31:20]; shift amount is instr[24:20].
- LUI: ctrl=add, A=0, B={instr[31:12],12'b0}.
- AUIPC: ctrl=add, A=pc_in, B={instr[31:12],12'b0}.

Illegal instructions:
- Any other opcode, or a bad funct7 on OP or a shift, is illegal.
- Result: illegal_out=1, ctrl=alu_add, rd_we_out=0, no busy bit set.

Scoreboard:
- One busy bit per register. x0 is never busy, and rd=0 gives rd_we_out=0.
- A source is used when: OP uses rs1 and rs2; OP-IMM uses rs1 only; LUI and AUIPC use neither.
- hazard = the instruction is valid and any used source register is busy.
- On accept with rd_we=1, set busy[rd].
- wb_valid_in clears busy[wb_addr_in].
- If set and clear hit the same register in the same cycle, set wins.

Flush:
- flush_in forces out_valid_out=0 next cycle.
- It clears the busy bit set by the flushed instruction.
- It accepts nothing that cycle.

Reset mid-operation:
- Takes effect immediately and asynchronously.
- Any in-flight instruction is lost and the scoreboard is cleared.

Optional Feature:
- Macro: ALU_ISSUE_BYPASS_EN.
- Defined: a writeback in the same cycle to a used source register satisfies the hazard check, and wb_data_in replaces the register file data for that operand.
- Undefined: the stage stalls until the cycle after wb_valid_in; wb_data_in is ignored.

Decomposition:
- Extend riscv_types with:
  - aluop_t (existing);
  - opcode constants OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC;
  - F3_* funct3 constants;
  - F7_BASE and F7_ALT;
  - a decoded-instruction struct.
- One natural sub-module: alu_scoreboard (busy bits, set/clear, hazard lookup).

Test Plan:
- Reset, then instr_in=0x002081B3 (add x3,x1,x2) with x1=5, x2=7 -> next cycle: out_valid=1, ctrl=alu_add, rs1_out=5, rs2_out=7, rd=3, rd_we=1, busy[3]=1.
- Accept 0x002081B3, then offer 0x00118233 (add x4,x3,x1) -> instr_ready_out=0. Assert wb_valid_in with wb_addr=3 -> accepted the same cycle if BYPASS is defined (rs1_out=wb_data_in), otherwise one cycle later.
- 0xFFF00293 (addi x5,x0,-1) -> rs1_out=0, rs2_out=0xFFFFFFFF, ctrl=alu_add.
- 0x123453B7 (lui x7,0x12345) -> rs1_out=0, rs2_out=0x12345000.
- 0x402081B3 (sub) -> ctrl=alu_sub. 0x422081B3 -> illegal_out=1, rd_we=0, busy unchanged.
- Backpressure: hold out_ready_in=0 for 3 cycles with the input valid -> outputs stable, instr_ready_out=0. Then flush_in -> out_valid=0 and busy[rd] cleared.
